// File: rtl/sonic_pkg.sv
// Shared types and constants for the ultrasonic ranging array.
// The optional averaging feature is enabled with the SONIC_AVG_EN macro in sonic_array.
package sonic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StStore
  } sonic_state_e;

  // Channel result word fields
  localparam int unsigned NewBit     = 31;
  localparam int unsigned TimeoutBit = 30;

  // Status word fields
  localparam int unsigned BusyBit    = 15;
  localparam int unsigned ChSelLsb   = 12;
  localparam int unsigned ChSelW     = 3;
  localparam int unsigned SampleCntW = 12;

  // All-ones value of a w-bit counter, reported when an echo times out
  function automatic logic [31:0] sat_value(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/sonic_sync_edge.sv
// Two-flop synchroniser for one asynchronous echo line, with rise/fall pulses
// derived from the synchronised level against its one-cycle delay.
module sonic_sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0] sync_q, sync_d;
  logic       last_q, last_d;

  always_comb begin
    sync_d = {sync_q[0], async_i};
    last_d = sync_q[1];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      last_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign rise_o = sync_q[1] & ~last_q;
  assign fall_o = ~sync_q[1] & last_q;

endmodule

// File: rtl/sonic_array.sv
// Round-robin ultrasonic ranging controller with an Avalon-MM read port.
// Define SONIC_AVG_EN to report the mean of the last four valid samples per channel.
module sonic_array
  import sonic_pkg::*;
#(
  parameter int unsigned  NUM_CH      = 4,
  parameter int unsigned  CNT_W       = 22,
  parameter int unsigned  TRIG_CYC    = 2000,
  parameter int unsigned  PERIOD_CYC  = 4194304,
  parameter int unsigned  TIMEOUT_CYC = 2097151,
  localparam int unsigned ADDR_W      = $clog2(NUM_CH + 1)
) (
  input  logic              av_mm_clk,
  input  logic              av_mm_rst,
  input  logic              av_mm_cs,
  input  logic              av_mm_read,
  input  logic [ADDR_W-1:0] av_mm_address,
  output logic [31:0]       av_mm_readdata,
  input  logic [NUM_CH-1:0] sonic_echo,
  output logic [NUM_CH-1:0] sonic_trigger
);

  localparam int unsigned      CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned      PER_W  = $clog2(PERIOD_CYC);
  localparam int unsigned      TRIG_W = $clog2(TRIG_CYC + 1);
  localparam logic [CNT_W-1:0] SatVal = CNT_W'(sat_value(CNT_W));

  logic [NUM_CH-1:0] echo_rise, echo_fall;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_sync
    sonic_sync_edge u_sync (
      .clk_i  (av_mm_clk),
      .rst_ni (av_mm_rst),
      .async_i(sonic_echo[g]),
      .rise_o (echo_rise[g]),
      .fall_o (echo_fall[g])
    );
  end

  // Period timer
  logic [PER_W-1:0] period_q, period_d;
  logic             start_tick;

  always_comb begin
    start_tick = (period_q == PER_W'(PERIOD_CYC - 1));
    period_d   = start_tick ? '0 : period_q + 1'b1;
  end

  // Measurement FSM
  sonic_state_e      state_q, state_d;
  logic [TRIG_W-1:0] trig_cnt_q, trig_cnt_d;
  logic [CNT_W-1:0]  to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0]  meas_q, meas_d;
  logic              meas_to_q, meas_to_d;
  logic [CH_W-1:0]   ch_sel_q, ch_sel_d;
  logic [NUM_CH-1:0] trigger_q, trigger_d;
  logic              rise_sel, fall_sel;

  assign rise_sel = echo_rise[ch_sel_q];
  assign fall_sel = echo_fall[ch_sel_q];

  always_comb begin
    state_d    = state_q;
    trig_cnt_d = trig_cnt_q;
    to_cnt_d   = to_cnt_q;
    meas_d     = meas_q;
    meas_to_d  = meas_to_q;
    ch_sel_d   = ch_sel_q;
    trigger_d  = trigger_q;
    unique case (state_q)
      StIdle: begin
        if (start_tick) begin
          state_d             = StTrig;
          trig_cnt_d          = '0;
          trigger_d           = '0;
          trigger_d[ch_sel_q] = 1'b1;
        end
      end
      StTrig: begin
        if (trig_cnt_q == TRIG_W'(TRIG_CYC - 1)) begin
          state_d   = StWaitRise;
          trigger_d = '0;
          to_cnt_d  = '0;
        end else begin
          trig_cnt_d = trig_cnt_q + 1'b1;
        end
      end
      StWaitRise, StMeasure: begin
        if (state_q == StMeasure && fall_sel) begin
          state_d   = StStore;
          meas_to_d = 1'b0;
        end else if (to_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d   = StStore;
          meas_d    = SatVal;
          meas_to_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
          if (state_q == StMeasure) begin
            meas_d = meas_q + 1'b1;
          end else if (rise_sel) begin
            // The rise cycle itself is the first high clock of the echo
            state_d = StMeasure;
            meas_d  = CNT_W'(1);
          end
        end
      end
      StStore: begin
        state_d  = StIdle;
        ch_sel_d = (ch_sel_q == CH_W'(NUM_CH - 1)) ? '0 : ch_sel_q + 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge av_mm_clk or negedge av_mm_rst) begin
    if (!av_mm_rst) begin
      period_q   <= '0;
      state_q    <= StIdle;
      trig_cnt_q <= '0;
      to_cnt_q   <= '0;
      meas_q     <= '0;
      meas_to_q  <= 1'b0;
      ch_sel_q   <= '0;
      trigger_q  <= '0;
    end else begin
      period_q   <= period_d;
      state_q    <= state_d;
      trig_cnt_q <= trig_cnt_d;
      to_cnt_q   <= to_cnt_d;
      meas_q     <= meas_d;
      meas_to_q  <= meas_to_d;
      ch_sel_q   <= ch_sel_d;
      trigger_q  <= trigger_d;
    end
  end

  assign sonic_trigger = trigger_q;

  // Results and register file
  logic [CNT_W-1:0]      val_q [NUM_CH];
  logic [CNT_W-1:0]      val_d [NUM_CH];
  logic [NUM_CH-1:0]     new_q, new_d;
  logic [NUM_CH-1:0]     flag_q, flag_d;
  logic [SampleCntW-1:0] sample_q, sample_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  store_en;

  assign store_en = (state_q == StStore);

`ifdef SONIC_AVG_EN
  logic [CNT_W-1:0] hist_q [NUM_CH][4];
  logic [CNT_W-1:0] hist_d [NUM_CH][4];
  logic [CNT_W+1:0] hist_sum;

  assign hist_sum = {2'b00, meas_q} + {2'b00, hist_q[ch_sel_q][0]}
                  + {2'b00, hist_q[ch_sel_q][1]} + {2'b00, hist_q[ch_sel_q][2]};

  always_ff @(posedge av_mm_clk or negedge av_mm_rst) begin
    if (!av_mm_rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) begin
        for (int unsigned e = 0; e < 4; e++) hist_q[c][e] <= '0;
      end
    end else begin
      hist_q <= hist_d;
    end
  end
`endif

  always_comb begin
    val_d    = val_q;
    new_d    = new_q;
    flag_d   = flag_q;
    sample_d = sample_q;
    rdata_d  = rdata_q;
`ifdef SONIC_AVG_EN
    hist_d   = hist_q;
`endif
    if (av_mm_cs && av_mm_read) begin
      rdata_d = '0;
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (av_mm_address == ADDR_W'(k)) begin
          rdata_d[NewBit]      = new_q[k];
          rdata_d[TimeoutBit]  = flag_q[k];
          rdata_d[CNT_W-1:0]   = val_q[k];
          new_d[k]             = 1'b0;
        end
      end
      if (av_mm_address == ADDR_W'(NUM_CH)) begin
        rdata_d[BusyBit]             = (state_q != StIdle);
        rdata_d[ChSelLsb +: CH_W]    = ch_sel_q;
        rdata_d[SampleCntW-1:0]      = sample_q;
      end
    end
    // A store landing on the same cycle as a read must keep new set
    if (store_en) begin
      new_d[ch_sel_q]  = 1'b1;
      flag_d[ch_sel_q] = meas_to_q;
      sample_d         = sample_q + 1'b1;
`ifdef SONIC_AVG_EN
      if (!meas_to_q) begin
        hist_d[ch_sel_q][3] = hist_q[ch_sel_q][2];
        hist_d[ch_sel_q][2] = hist_q[ch_sel_q][1];
        hist_d[ch_sel_q][1] = hist_q[ch_sel_q][0];
        hist_d[ch_sel_q][0] = meas_q;
        val_d[ch_sel_q]     = hist_sum[CNT_W+1:2];
      end
`else
      val_d[ch_sel_q] = meas_q;
`endif
    end
  end

  always_ff @(posedge av_mm_clk or negedge av_mm_rst) begin
    if (!av_mm_rst) begin
      for (int unsigned c = 0; c < NUM_CH; c++) val_q[c] <= '0;
      new_q    <= '0;
      flag_q   <= '0;
      sample_q <= '0;
      rdata_q  <= '0;
    end else begin
      val_q    <= val_d;
      new_q    <= new_d;
      flag_q   <= flag_d;
      sample_q <= sample_d;
      rdata_q  <= rdata_d;
    end
  end

  assign av_mm_readdata = rdata_q;

endmodule
